// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a one-entry skid buffer so upstream can keep
// streaming while downstream stalls; also counts back-pressured cycles.
module mem_wb_skid #(
    parameter int DATA_W      = 64,
    parameter int IDX_W       = 5,
    parameter int CNT_W       = 16,
    parameter bit X0_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic              wb_i,
    input  logic              rmem_i,
    input  logic              wmem_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] raddr_o,
    output logic [DATA_W-1:0] result_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    output logic              wb_o,
    output logic              rmem_o,
    output logic              wmem_o,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] raddr;
        logic [DATA_W-1:0] result;
        logic [IDX_W-1:0]  rd_idx;
        logic              wb;
        logic              rmem;
        logic              wmem;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_beat;
    logic   in_fire;
    logic   out_fire;

    assign in_beat  = '{raddr: raddr_i, result: result_i, rd_idx: rd_idx_i,
                        wb: wb_i, rmem: rmem_i, wmem: wmem_i};
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL) && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // NOTE: occ gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        occ = 2'd0;
        case (state)
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: data registers are reset as well, because raddr_o/result_o stay visible while idle.
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates, so every branch below sees pre-edge state and counters.
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;

            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q <= in_beat;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_beat;
                        end else if (in_fire) begin
                            skid_q <= in_beat;
                            state  <= FULL;
                        end else if (out_fire) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign raddr_o  = main_q.raddr;
    assign result_o = main_q.result;
    assign rd_idx_o = main_q.rd_idx;
    // x0 is hardwired zero, so a write to it is dropped here rather than in the regfile.
    assign wb_o     = out_valid && main_q.wb && !(X0_SUPPRESS && (main_q.rd_idx == '0));
    assign rmem_o   = out_valid && main_q.rmem;
    assign wmem_o   = out_valid && main_q.wmem;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: directed vector table, hand-written reset/saturation
// sequences, and random traffic against a queue-based reference model.
module tb_mem_wb_skid;

    localparam int DW        = 64;
    localparam int IW        = 5;
    localparam int CW        = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] raddr;
        logic [DW-1:0] result;
        logic [IW-1:0] rd;
        logic          wb;
        logic          rmem;
        logic          wmem;
    } ent_t;

    typedef struct {
        string  name;
        int     fl, iv, ordy;
        longint res;
        int     rd, wb, rm, wm;
        int     e_ov, e_irdy, e_occ;
        longint e_res;
        int     e_rd, e_wb, e_rm, e_wm, e_stall;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] raddr_i;
    logic [DW-1:0] result_i;
    logic [IW-1:0] rd_idx_i;
    logic          wb_i, rmem_i, wmem_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] raddr_o;
    logic [DW-1:0] result_o;
    logic [IW-1:0] rd_idx_o;
    logic          wb_o, rmem_o, wmem_o;
    logic [1:0]    occ;
    logic [CW-1:0] stall_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t model_q[$];
    ent_t last_main;
    int   model_stall;
    vec_t tbl[22];

    mem_wb_skid #(.DATA_W(DW), .IDX_W(IW), .CNT_W(CW), .X0_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .raddr_i(raddr_i), .result_i(result_i), .rd_idx_i(rd_idx_i),
        .wb_i(wb_i), .rmem_i(rmem_i), .wmem_i(wmem_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .raddr_o(raddr_o), .result_o(result_o), .rd_idx_o(rd_idx_o),
        .wb_o(wb_o), .rmem_o(rmem_o), .wmem_o(wmem_o),
        .occ(occ), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic iv, input logic ordy, input ent_t e);
        rst       = r;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        raddr_i   = e.raddr;
        result_i  = e.result;
        rd_idx_i  = e.rd;
        wb_i      = e.wb;
        rmem_i    = e.rmem;
        wmem_i    = e.wmem;
    endtask

    // Reference: a FIFO of at most two beats; the head is what the output shows.
    task automatic model_step(input logic r, input logic fl, input logic iv, input logic ordy, input ent_t e);
        int   sz;
        logic ov, irdy;
        if (!r) begin
            model_q.delete();
            last_main   = '0;
            model_stall = 0;
            return;
        end
        sz   = model_q.size();
        ov   = (sz != 0);
        irdy = (sz < 2) && !fl;
        if (ov && !ordy && model_stall < STALL_MAX) model_stall++;
        if (fl) begin
            model_q.delete();
        end else begin
            if (ov && ordy) void'(model_q.pop_front());
            if (iv && irdy) model_q.push_back(e);
        end
        if (model_q.size() != 0) last_main = model_q[0];
    endtask

    task automatic model_check();
        int   sz;
        logic ov;
        ent_t h;
        sz = model_q.size();
        ov = (sz != 0);
        h  = ov ? model_q[0] : last_main;
        check("out_valid", 64'(out_valid), 64'(ov));
        check("in_ready",  64'(in_ready),  64'((sz < 2) && !flush));
        check("occ",       64'(occ),       64'(sz));
        check("raddr_o",   raddr_o,        h.raddr);
        check("result_o",  result_o,       h.result);
        check("rd_idx_o",  64'(rd_idx_o),  64'(h.rd));
        check("wb_o",      64'(wb_o),      64'(ov && h.wb && (h.rd != 0)));
        check("rmem_o",    64'(rmem_o),    64'(ov && h.rmem));
        check("wmem_o",    64'(wmem_o),    64'(ov && h.wmem));
        check("stall_cnt", 64'(stall_cnt), 64'(model_stall));
    endtask

    task automatic cycle(input logic r, input logic fl, input logic iv, input logic ordy, input ent_t e);
        drive(r, fl, iv, ordy, e);
        @(negedge clk);
        model_check();
        model_step(r, fl, iv, ordy, e);
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.raddr  = {$urandom, $urandom};
        e.result = {$urandom, $urandom};
        e.rd     = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(1, 31));
        e.wb     = 1'($urandom);
        e.rmem   = 1'($urandom);
        e.wmem   = 1'($urandom);
        return e;
    endfunction

    initial begin
        ent_t e, e1, e2, e3, zero;
        zero = '0;

        // name, fl,iv,ordy, res,rd,wb,rm,wm | ov,irdy,occ, res_o,rd_o,wb_o,rm_o,wm_o, stall
        tbl[0]  = '{"rst_state", 0,1,1, 1,    1,1,0,0, 0,1,0, 0,    0,0,0,0, 0};
        tbl[1]  = '{"stream1",   0,1,1, 2,    1,1,0,0, 1,1,1, 1,    1,1,0,0, 0};
        tbl[2]  = '{"stream2",   0,1,1, 3,    1,1,0,0, 1,1,1, 2,    1,1,0,0, 0};
        tbl[3]  = '{"stream3",   0,1,1, 4,    1,1,0,0, 1,1,1, 3,    1,1,0,0, 0};
        tbl[4]  = '{"stream4",   0,0,1, 0,    0,0,0,0, 1,1,1, 4,    1,1,0,0, 0};
        tbl[5]  = '{"drained",   0,0,1, 0,    0,0,0,0, 0,1,0, 4,    1,0,0,0, 0};
        tbl[6]  = '{"bp_push_a", 0,1,0, 'h10, 2,1,0,0, 0,1,0, 4,    1,0,0,0, 0};
        tbl[7]  = '{"bp_push_b", 0,1,0, 'h20, 3,1,0,0, 1,1,1, 'h10, 2,1,0,0, 0};
        tbl[8]  = '{"bp_full",   0,1,0, 'h99, 7,1,0,0, 1,0,2, 'h10, 2,1,0,0, 1};
        tbl[9]  = '{"bp_hold",   0,0,0, 0,    0,0,0,0, 1,0,2, 'h10, 2,1,0,0, 2};
        tbl[10] = '{"bp_pop_a",  0,0,1, 0,    0,0,0,0, 1,0,2, 'h10, 2,1,0,0, 3};
        tbl[11] = '{"bp_pop_b",  0,0,1, 0,    0,0,0,0, 1,1,1, 'h20, 3,1,0,0, 3};
        tbl[12] = '{"bp_empty",  0,0,1, 0,    0,0,0,0, 0,1,0, 'h20, 3,0,0,0, 3};
        tbl[13] = '{"fl_push1",  0,1,0, 'h40, 4,1,1,0, 0,1,0, 'h20, 3,0,0,0, 3};
        tbl[14] = '{"fl_push2",  0,1,0, 'h50, 6,1,0,1, 1,1,1, 'h40, 4,1,1,0, 3};
        tbl[15] = '{"fl_flush",  1,1,0, 'h30, 9,1,1,1, 1,0,2, 'h40, 4,1,1,0, 4};
        tbl[16] = '{"fl_after",  0,0,1, 0,    0,0,0,0, 0,1,0, 'h40, 4,0,0,0, 5};
        tbl[17] = '{"fl_no_c",   0,0,1, 0,    0,0,0,0, 0,1,0, 'h40, 4,0,0,0, 5};
        tbl[18] = '{"x0_push0",  0,1,1, 'h60, 0,1,0,1, 0,1,0, 'h40, 4,0,0,0, 5};
        tbl[19] = '{"x0_push5",  0,1,1, 'h70, 5,1,0,0, 1,1,1, 'h60, 0,0,0,1, 5};
        tbl[20] = '{"x0_show5",  0,0,1, 0,    0,0,0,0, 1,1,1, 'h70, 5,1,0,0, 5};
        tbl[21] = '{"x0_idle",   0,0,1, 0,    0,0,0,0, 0,1,0, 'h70, 5,0,0,0, 5};

        drive(1'b0, 1'b0, 1'b0, 1'b0, zero);
        model_step(1'b0, 1'b0, 1'b0, 1'b0, zero);
        repeat (2) @(posedge clk);
        #1;

        // Directed table: expectations are what the DUT shows during the row's cycle.
        for (int i = 0; i < 22; i++) begin
            e.raddr  = 64'(tbl[i].res) << 4;
            e.result = 64'(tbl[i].res);
            e.rd     = IW'(tbl[i].rd);
            e.wb     = tbl[i].wb != 0;
            e.rmem   = tbl[i].rm != 0;
            e.wmem   = tbl[i].wm != 0;
            drive(1'b1, tbl[i].fl != 0, tbl[i].iv != 0, tbl[i].ordy != 0, e);
            @(negedge clk);
            check({tbl[i].name, ".out_valid"}, 64'(out_valid), 64'(tbl[i].e_ov));
            check({tbl[i].name, ".in_ready"},  64'(in_ready),  64'(tbl[i].e_irdy));
            check({tbl[i].name, ".occ"},       64'(occ),       64'(tbl[i].e_occ));
            check({tbl[i].name, ".result_o"},  result_o,       64'(tbl[i].e_res));
            check({tbl[i].name, ".raddr_o"},   raddr_o,        64'(tbl[i].e_res) << 4);
            check({tbl[i].name, ".rd_idx_o"},  64'(rd_idx_o),  64'(tbl[i].e_rd));
            check({tbl[i].name, ".wb_o"},      64'(wb_o),      64'(tbl[i].e_wb));
            check({tbl[i].name, ".rmem_o"},    64'(rmem_o),    64'(tbl[i].e_rm));
            check({tbl[i].name, ".wmem_o"},    64'(wmem_o),    64'(tbl[i].e_wm));
            check({tbl[i].name, ".stall_cnt"}, 64'(stall_cnt), 64'(tbl[i].e_stall));
            model_step(1'b1, flush, in_valid, out_ready, e);
            @(posedge clk);
            #1;
        end

        // Reset while FULL, with handshakes active in the reset cycle.
        e1 = '{raddr: 64'hA0, result: 64'hA1, rd: 5'd7, wb: 1'b1, rmem: 1'b1, wmem: 1'b0};
        e2 = '{raddr: 64'hB0, result: 64'hB1, rd: 5'd8, wb: 1'b1, rmem: 1'b0, wmem: 1'b1};
        e3 = '{raddr: 64'hC0, result: 64'hC1, rd: 5'd9, wb: 1'b1, rmem: 1'b1, wmem: 1'b1};
        cycle(1'b1, 1'b0, 1'b1, 1'b0, e1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, e2);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, e3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, zero);
        @(negedge clk);
        check("rst_mid.occ",       64'(occ),       64'd0);
        check("rst_mid.stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_mid.out_valid", 64'(out_valid), 64'd0);
        check("rst_mid.in_ready",  64'(in_ready),  64'd1);
        check("rst_mid.result_o",  result_o,       64'd0);
        check("rst_mid.raddr_o",   raddr_o,        64'd0);
        check("rst_mid.flags",     64'({wb_o, rmem_o, wmem_o, rd_idx_o}), 64'd0);
        model_step(1'b1, 1'b0, 1'b0, 1'b0, zero);
        @(posedge clk);
        #1;

        // Stall counter saturation: one beat held under back-pressure for 20 cycles.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, e1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, zero);
        drive(1'b1, 1'b0, 1'b0, 1'b0, zero);
        @(negedge clk);
        check("sat.stall_cnt", 64'(stall_cnt), 64'(STALL_MAX));
        check("sat.result_o",  result_o,       64'hA1);
        model_step(1'b1, 1'b0, 1'b0, 1'b0, zero);
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, zero);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, zero);

        // Random traffic, with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  rand_ent());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
